// File: rtl/mux2to1_5bit_sync.sv
// 2-to-1 selector for narrow fields such as a register index (rt vs rd).
// muxout is the same-cycle combinational choice. muxout_q/valid_q are a
// registered copy plus a flag for the next pipeline stage.
module mux2to1_5bit_sync #(
    parameter int                WIDTH     = 5,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sel,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    output logic [WIDTH-1:0] muxout,
    output logic [WIDTH-1:0] muxout_q,
    output logic             valid_q
);

    // Combinational select. The if/else form makes an unknown or floating
    // sel fall through to din1 instead of blending the two inputs.
    always_comb begin
        muxout = din1;
        if (sel == 1'b1) begin
            muxout = din2;
        end
    end

    // Registered copy. Reset wins over enable; valid_q marks data captured
    // since the last reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            muxout_q <= RESET_VAL;
            valid_q  <= 1'b0;
        end else if (en) begin
            muxout_q <= muxout;
            valid_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux2to1_5bit_sync.sv
// Directed and random checks of mux2to1_5bit_sync against a behavioural model.
module tb_mux2to1_5bit_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       sel;
    logic [4:0] din1;
    logic [4:0] din2;
    logic [4:0] muxout;
    logic [4:0] muxout_q;
    logic       valid_q;

    int checks   = 0;
    int failures = 0;

    // Model state: the value and flag the registered path should hold.
    logic [4:0] mdl_q;
    logic       mdl_v;

    always #5 clk = ~clk;

    mux2to1_5bit_sync dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sel      (sel),
        .din1     (din1),
        .din2     (din2),
        .muxout   (muxout),
        .muxout_q (muxout_q),
        .valid_q  (valid_q)
    );

    // Only a definite 1 picks din2; anything else picks din1.
    function automatic logic [4:0] pick(input logic s, input logic [4:0] a, input logic [4:0] b);
        return (s === 1'b1) ? b : a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_comb(input string tag);
        #1;
        chk(tag, {27'd0, muxout}, {27'd0, pick(sel, din1, din2)});
    endtask

    // Advance one clock edge, update the model from the inputs present at
    // that edge, then check all outputs shortly after the edge.
    task automatic step(input string tag);
        logic [4:0] nq;
        logic       nv;
        nq = mdl_q;
        nv = mdl_v;
        if (rst === 1'b1) begin
            nq = 5'd0;
            nv = 1'b0;
        end else if (en === 1'b1) begin
            nq = pick(sel, din1, din2);
            nv = 1'b1;
        end
        @(posedge clk);
        #1;
        mdl_q = nq;
        mdl_v = nv;
        chk({tag, "_q"}, {27'd0, muxout_q}, {27'd0, mdl_q});
        chk({tag, "_v"}, {31'd0, valid_q}, {31'd0, mdl_v});
        chk({tag, "_comb"}, {27'd0, muxout}, {27'd0, pick(sel, din1, din2)});
    endtask

    initial begin
        mdl_q = 'x;
        mdl_v = 'x;
        rst  = 1'b1;
        en   = 1'b0;
        sel  = 1'b0;
        din1 = 5'd0;
        din2 = 5'd0;
        step("init_rst");
        chk("init_q_zero", {27'd0, muxout_q}, 32'd0);
        chk("init_v_zero", {31'd0, valid_q}, 32'd0);

        // Combinational path holds over 100 ns, then follows sel immediately.
        rst  = 1'b0;
        sel  = 1'b0;
        din1 = 5'd10;
        din2 = 5'd30;
        for (int i = 0; i < 10; i++) begin
            #10;
            chk("hold_sel0", {27'd0, muxout}, 32'd10);
        end
        sel = 1'b1;
        #1;
        chk("sel1_now", {27'd0, muxout}, 32'd30);

        // Reset for two edges with en high; muxout keeps tracking.
        @(negedge clk);
        rst  = 1'b1;
        en   = 1'b1;
        sel  = 1'b1;
        din2 = 5'd7;
        step("rst_a");
        step("rst_b");
        chk("rst_q", {27'd0, muxout_q}, 32'd0);
        chk("rst_v", {31'd0, valid_q}, 32'd0);
        chk("rst_comb", {27'd0, muxout}, 32'd7);
        rst = 1'b0;
        step("rel");
        chk("rel_q7", {27'd0, muxout_q}, 32'd7);
        chk("rel_v1", {31'd0, valid_q}, 32'd1);

        // Capture all-ones, then hold with en low while inputs change.
        sel  = 1'b0;
        din1 = 5'd31;
        step("cap31");
        chk("cap31_q", {27'd0, muxout_q}, 32'd31);
        en   = 1'b0;
        sel  = 1'b1;
        din2 = 5'd4;
        for (int i = 0; i < 3; i++) begin
            step("hold_en0");
            chk("hold_q31", {27'd0, muxout_q}, 32'd31);
            chk("hold_comb4", {27'd0, muxout}, 32'd4);
        end
        en = 1'b1;
        step("reen");
        chk("reen_q4", {27'd0, muxout_q}, 32'd4);

        // Toggle sel every cycle; muxout_q trails by one edge.
        din1 = 5'd5;
        din2 = 5'd26;
        sel  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sel = ~sel;
            chk_comb("tog_comb");
            step("tog");
        end
        chk("tog_last26", {27'd0, muxout_q}, 32'd26);

        // Mid-stream reset with en high.
        rst = 1'b1;
        step("mid_rst");
        chk("mid_rst_q", {27'd0, muxout_q}, 32'd0);
        chk("mid_rst_v", {31'd0, valid_q}, 32'd0);
        rst = 1'b0;

        // Unknown sel selects din1; equal inputs give the common value.
        sel  = 1'bx;
        din1 = 5'd9;
        din2 = 5'd22;
        #1;
        chk("selx", {27'd0, muxout}, 32'd9);
        din1 = 5'd0;
        din2 = 5'd0;
        for (int i = 0; i < 4; i++) begin
            sel = i[0];
            #1;
            chk("eq_zero", {27'd0, muxout}, 32'd0);
            step("eq_zero_clk");
        end

        // Random traffic; inputs change between edges, sampled at the edge.
        for (int i = 0; i < 300; i++) begin
            rst  = ($urandom_range(0, 15) == 0);
            en   = $urandom_range(0, 1) == 1;
            sel  = $urandom_range(0, 1) == 1;
            din1 = 5'($urandom);
            din2 = 5'($urandom);
            chk_comb("rnd_comb");
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
